tri_setup: RTL and testbench

- Triangle setup stage directly downstream of the three-vertex FIFO collector.
- Captures one triangle (three vertices plus three colors) when the collector signals ready, then pulses dequeue back to it.
- Computes edge-function coefficients, doubled signed area and a screen-clamped bounding box.
- Culls degenerate and fully off-screen triangles; hands surviving triangles to the rasterizer over a valid/ready handshake.

---
 rtl/tri_setup.sv | 181 ++++++++++++++++++
 tb/tb_tri_setup.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_setup.sv
// tri_setup: captures one triangle from the vertex collector, computes edge coefficients,
// doubled area and a screen-clamped bounding box, culls and hands survivors to the rasterizer.
module tri_setup #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ready_in,
    input  logic [95:0] vertex_in,
    input  logic [95:0] vertex_in2,
    input  logic [95:0] vertex_in3,
    input  logic [95:0] color_in,
    input  logic [95:0] color_in2,
    input  logic [95:0] color_in3,
    output logic        dequeue,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] edge_a0,
    output logic [16:0] edge_a1,
    output logic [16:0] edge_a2,
    output logic [16:0] edge_b0,
    output logic [16:0] edge_b1,
    output logic [16:0] edge_b2,
    output logic [32:0] edge_c0,
    output logic [32:0] edge_c1,
    output logic [32:0] edge_c2,
    output logic [34:0] area2,
    output logic        flipped,
    output logic [15:0] bbox_xmin,
    output logic [15:0] bbox_xmax,
    output logic [15:0] bbox_ymin,
    output logic [15:0] bbox_ymax,
    output logic [31:0] z_out0,
    output logic [31:0] z_out1,
    output logic [31:0] z_out2,
    output logic [95:0] color_out0,
    output logic [95:0] color_out1,
    output logic [95:0] color_out2,
    output logic [15:0] cull_count
);
    typedef enum logic [2:0] {IDLE, EDGE0, EDGE1, EDGE2, AREA, DECIDE, OUT} state_t;
    localparam logic signed [15:0] XM = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] YM = 16'(SCREEN_H - 1);

    state_t state_q, state_d;
    logic signed [15:0] xi_q[3], yi_q[3];
    logic [31:0] z_q[3];
    logic [95:0] col_q[3];
    logic signed [16:0] a_q[3], b_q[3];
    logic signed [32:0] c_q[3];
    logic signed [34:0] area_q;
    logic signed [15:0] minx_q, maxx_q, miny_q, maxy_q;
    logic [15:0] bx0_q, bx1_q, by0_q, by1_q, cull_q;
    logic flip_q, valid_q, deq_q;

    logic [1:0] ea, eb;
    logic signed [31:0] p1, p2;
    logic signed [16:0] a_n, b_n;
    logic signed [32:0] c_n;
    logic cull, capture;

    function automatic logic signed [15:0] mn(input logic signed [15:0] a, b, c);
        mn = a < b ? (a < c ? a : c) : (b < c ? b : c);
    endfunction

    function automatic logic signed [15:0] mx(input logic signed [15:0] a, b, c);
        mx = a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction

    // One multiplier pair, steered to the edge selected by the current EDGEk state.
    always_comb begin
        ea = state_q == EDGE1 ? 2'd1 : state_q == EDGE2 ? 2'd2 : 2'd0;
        eb = ea == 2'd2 ? 2'd0 : ea + 2'd1;
        p1 = 32'(xi_q[ea]) * 32'(yi_q[eb]);
        p2 = 32'(xi_q[eb]) * 32'(yi_q[ea]);
        a_n = 17'(yi_q[ea]) - 17'(yi_q[eb]);
        b_n = 17'(xi_q[eb]) - 17'(xi_q[ea]);
        c_n = 33'(p1) - 33'(p2);
        capture = state_q == IDLE && ready_in;
        cull = area_q == '0 || maxx_q[15] || minx_q > XM || maxy_q[15] || miny_q > YM;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ready_in ? EDGE0 : IDLE;
            EDGE0:   state_d = EDGE1;
            EDGE1:   state_d = EDGE2;
            EDGE2:   state_d = AREA;
            AREA:    state_d = DECIDE;
            DECIDE:  state_d = cull ? IDLE : OUT;
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            deq_q <= 1'b0;
            valid_q <= 1'b0;
            flip_q <= 1'b0;
            area_q <= '0;
            {minx_q, maxx_q, miny_q, maxy_q} <= '0;
            {bx0_q, bx1_q, by0_q, by1_q, cull_q} <= '0;
            for (int k = 0; k < 3; k++) begin
                xi_q[k] <= '0;
                yi_q[k] <= '0;
                z_q[k] <= '0;
                col_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            deq_q <= capture;
            if (capture) begin
                xi_q[0] <= vertex_in[95:80];
                xi_q[1] <= vertex_in2[95:80];
                xi_q[2] <= vertex_in3[95:80];
                yi_q[0] <= vertex_in[63:48];
                yi_q[1] <= vertex_in2[63:48];
                yi_q[2] <= vertex_in3[63:48];
                z_q[0] <= vertex_in[31:0];
                z_q[1] <= vertex_in2[31:0];
                z_q[2] <= vertex_in3[31:0];
                col_q[0] <= color_in;
                col_q[1] <= color_in2;
                col_q[2] <= color_in3;
            end
            if (state_q inside {EDGE0, EDGE1, EDGE2}) begin
                a_q[ea] <= a_n;
                b_q[ea] <= b_n;
                c_q[ea] <= c_n;
            end
            if (state_q == AREA) begin
                area_q <= 35'(c_q[0]) + 35'(c_q[1]) + 35'(c_q[2]);
                minx_q <= mn(xi_q[0], xi_q[1], xi_q[2]);
                maxx_q <= mx(xi_q[0], xi_q[1], xi_q[2]);
                miny_q <= mn(yi_q[0], yi_q[1], yi_q[2]);
                maxy_q <= mx(yi_q[0], yi_q[1], yi_q[2]);
            end
            if (state_q == DECIDE) begin
                if (cull) begin
                    cull_q <= cull_q + 16'd1;
                end else begin
                    valid_q <= 1'b1;
                    flip_q <= area_q[34];
                    // Surviving boxes already overlap the screen, so each side needs one clamp only.
                    bx0_q <= minx_q[15] ? '0 : minx_q;
                    bx1_q <= maxx_q > XM ? XM : maxx_q;
                    by0_q <= miny_q[15] ? '0 : miny_q;
                    by1_q <= maxy_q > YM ? YM : maxy_q;
                    if (area_q[34]) begin
                        area_q <= -area_q;
                        for (int k = 0; k < 3; k++) begin
                            a_q[k] <= -a_q[k];
                            b_q[k] <= -b_q[k];
                            c_q[k] <= -c_q[k];
                        end
                    end
                end
            end
            if (state_q == OUT && out_ready) valid_q <= 1'b0;
        end
    end

    assign dequeue = deq_q;
    assign out_valid = valid_q;
    assign {edge_a0, edge_a1, edge_a2} = {a_q[0], a_q[1], a_q[2]};
    assign {edge_b0, edge_b1, edge_b2} = {b_q[0], b_q[1], b_q[2]};
    assign {edge_c0, edge_c1, edge_c2} = {c_q[0], c_q[1], c_q[2]};
    assign area2 = area_q;
    assign flipped = flip_q;
    assign {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} = {bx0_q, bx1_q, by0_q, by1_q};
    assign {z_out0, z_out1, z_out2} = {z_q[0], z_q[1], z_q[2]};
    assign {color_out0, color_out1, color_out2} = {col_q[0], col_q[1], col_q[2]};
    assign cull_count = cull_q;
endmodule

// File: tb/tb_tri_setup.sv
// tb_tri_setup: directed triangles checked against an arithmetic setup model plus literal expectations.
module tb_tri_setup;
    localparam int W = 640;
    localparam int H = 480;

    logic clk = 1'b0, rst_n, ready_in, out_ready;
    logic [95:0] vertex_in, vertex_in2, vertex_in3, color_in, color_in2, color_in3;
    logic dequeue, out_valid, flipped;
    logic [16:0] edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2;
    logic [32:0] edge_c0, edge_c1, edge_c2;
    logic [34:0] area2;
    logic [15:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, cull_count;
    logic [31:0] z_out0, z_out1, z_out2;
    logic [95:0] color_out0, color_out1, color_out2;

    int checks = 0, errors = 0;
    logic [684:0] exp_q[$];

    tri_setup #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .ready_in(ready_in),
        .vertex_in(vertex_in), .vertex_in2(vertex_in2), .vertex_in3(vertex_in3),
        .color_in(color_in), .color_in2(color_in2), .color_in3(color_in3),
        .dequeue(dequeue), .out_valid(out_valid), .out_ready(out_ready),
        .edge_a0(edge_a0), .edge_a1(edge_a1), .edge_a2(edge_a2),
        .edge_b0(edge_b0), .edge_b1(edge_b1), .edge_b2(edge_b2),
        .edge_c0(edge_c0), .edge_c1(edge_c1), .edge_c2(edge_c2),
        .area2(area2), .flipped(flipped),
        .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
        .z_out0(z_out0), .z_out1(z_out1), .z_out2(z_out2),
        .color_out0(color_out0), .color_out1(color_out1), .color_out2(color_out2),
        .cull_count(cull_count)
    );

    always #5 clk = ~clk;

    // Bit 301 = cull; [300:0] = {A0..2, B0..2, C0..2, area2, flipped, xmin, xmax, ymin, ymax}.
    function automatic logic [301:0] geom(input logic [95:0] p0, p1, p2);
        logic [95:0] p[3];
        longint x[3], y[3], a[3], b[3], c[3], ar, s, mnx, mxx, mny, mxy;
        bit cl;
        p[0] = p0; p[1] = p1; p[2] = p2;
        for (int k = 0; k < 3; k++) begin
            x[k] = longint'($signed(p[k][95:80]));
            y[k] = longint'($signed(p[k][63:48]));
        end
        mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
        for (int k = 0; k < 3; k++) begin
            a[k] = y[k] - y[(k + 1) % 3];
            b[k] = x[(k + 1) % 3] - x[k];
            c[k] = x[k] * y[(k + 1) % 3] - x[(k + 1) % 3] * y[k];
            if (x[k] < mnx) mnx = x[k];
            if (x[k] > mxx) mxx = x[k];
            if (y[k] < mny) mny = y[k];
            if (y[k] > mxy) mxy = y[k];
        end
        ar = c[0] + c[1] + c[2];
        cl = ar == 0 || mxx < 0 || mnx > W - 1 || mxy < 0 || mny > H - 1;
        s = ar < 0 ? -1 : 1;
        return {cl, 17'(s * a[0]), 17'(s * a[1]), 17'(s * a[2]), 17'(s * b[0]), 17'(s * b[1]), 17'(s * b[2]),
                33'(s * c[0]), 33'(s * c[1]), 33'(s * c[2]), 35'(s * ar), ar < 0,
                16'(mnx < 0 ? 0 : mnx), 16'(mxx > W - 1 ? W - 1 : mxx),
                16'(mny < 0 ? 0 : mny), 16'(mxy > H - 1 ? H - 1 : mxy)};
    endfunction

    function automatic logic [95:0] vtx(input int x, input int y);
        return {16'(x), 16'h4321, 16'(y), 16'h8765, 32'($urandom())};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic load(input int x0, y0, x1, y1, x2, y2);
        vertex_in = vtx(x0, y0);
        vertex_in2 = vtx(x1, y1);
        vertex_in3 = vtx(x2, y2);
        color_in = {$urandom(), $urandom(), $urandom()};
        color_in2 = {$urandom(), $urandom(), $urandom()};
        color_in3 = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic push_exp;
        logic [301:0] g;
        g = geom(vertex_in, vertex_in2, vertex_in3);
        exp_q.push_back({g[300:0], vertex_in[31:0], vertex_in2[31:0], vertex_in3[31:0],
                         color_in, color_in2, color_in3});
    endtask

    // Leaves the caller just after the edge at which out_valid rises (or the cull lands).
    task automatic run_tri(input int x0, y0, x1, y1, x2, y2);
        logic [301:0] g;
        logic [15:0] old;
        load(x0, y0, x1, y1, x2, y2);
        g = geom(vertex_in, vertex_in2, vertex_in3);
        old = cull_count;
        if (!g[301]) push_exp();
        ready_in = 1'b1;
        tick;
        chk("dequeue_pulse", dequeue, 1);
        ready_in = 1'b0;
        tick;
        chk("dequeue_end", dequeue, 0);
        repeat (3) tick;
        if (g[301]) begin
            chk("cull_hold", cull_count, old);
            tick;
            chk("cull_inc", cull_count, 16'(old + 16'd1));
            chk("cull_no_valid", out_valid, 0);
        end else begin
            chk("valid_early", out_valid, 0);
            tick;
            chk("valid_latency", out_valid, 1);
        end
    endtask

    task automatic finish_hs;
        tick;
        chk("valid_drop", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got 1 expected 0");
            end else begin
                checks += 2;
                if ({edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2, edge_c0, edge_c1, edge_c2,
                     area2, flipped, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} != exp_q[0][684:384]) begin
                    errors++;
                    $display("FAIL geom got %h expected %h", {edge_a0, edge_a1, edge_a2, edge_b0, edge_b1,
                             edge_b2, edge_c0, edge_c1, edge_c2, area2, flipped, bbox_xmin, bbox_xmax,
                             bbox_ymin, bbox_ymax}, exp_q[0][684:384]);
                end
                if ({z_out0, z_out1, z_out2, color_out0, color_out1, color_out2} != exp_q[0][383:0]) begin
                    errors++;
                    $display("FAIL passthru got %h expected %h",
                             {z_out0, z_out1, z_out2, color_out0, color_out1, color_out2}, exp_q[0][383:0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ready_in = 1'b0;
        out_ready = 1'b1;
        load(0, 0, 0, 0, 0, 0);
        repeat (2) tick;
        chk("rst_dequeue", dequeue, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_flipped", flipped, 0);
        chk("rst_area", area2, 0);
        chk("rst_cull", cull_count, 0);
        chk("rst_c1", edge_c1, 0);
        chk("rst_bbox", bbox_xmax, 0);
        chk("rst_color", color_out2, 0);
        rst_n = 1'b1;
        tick;

        run_tri(0, 0, 10, 0, 0, 10);
        chk("ccw_a1", $signed(edge_a1), -10);
        chk("ccw_b0", $signed(edge_b0), 10);
        chk("ccw_c1", $signed(edge_c1), 100);
        chk("ccw_area", $signed(area2), 100);
        chk("ccw_flip", flipped, 0);
        chk("ccw_xmax", bbox_xmax, 10);
        chk("ccw_ymax", bbox_ymax, 10);
        finish_hs;

        run_tri(0, 0, 0, 10, 10, 0);
        chk("cw_flip", flipped, 1);
        chk("cw_area", $signed(area2), 100);
        chk("cw_a0", $signed(edge_a0), 10);
        chk("cw_b2", $signed(edge_b2), 10);
        chk("cw_c1", $signed(edge_c1), 100);
        finish_hs;

        run_tri(0, 0, 5, 5, 10, 10);
        chk("degen_count", cull_count, 1);
        run_tri(700, 0, 710, 0, 700, 10);
        chk("offscreen_count", cull_count, 2);

        run_tri(-5, -5, 20, 0, 0, 20);
        chk("clamp_xmin", bbox_xmin, 0);
        chk("clamp_xmax", bbox_xmax, 20);
        chk("clamp_ymin", bbox_ymin, 0);
        chk("clamp_ymax", bbox_ymax, 20);
        chk("clamp_area", $signed(area2), 600);
        finish_hs;

        // Backpressure: collector keeps ready_in high and presents the next triangle after dequeue.
        out_ready = 1'b0;
        load(10, 10, 200, 20, 50, 300);
        push_exp();
        ready_in = 1'b1;
        tick;
        chk("bp_dequeue", dequeue, 1);
        load(-100, -50, 800, 100, 300, 700);
        push_exp();
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("bp_no_dequeue", dequeue, 0);
        end
        chk("bp_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick;
        chk("bp_hs_drop", out_valid, 0);
        chk("bp_hs_nodeq", dequeue, 0);
        tick;
        chk("bp_next_dequeue", dequeue, 1);
        ready_in = 1'b0;
        repeat (5) tick;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_clamp_xmax", bbox_xmax, 639);
        chk("bp_clamp_ymax", bbox_ymax, 479);
        chk("bp_clamp_xmin", bbox_xmin, 0);
        finish_hs;

        // Reset while the triangle sits in EDGE1.
        load(1, 1, 50, 1, 1, 50);
        ready_in = 1'b1;
        tick;
        chk("mid_dequeue", dequeue, 1);
        ready_in = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dequeue", dequeue, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cull", cull_count, 0);
        chk("mid_rst_a0", edge_a0, 0);
        chk("mid_rst_z", z_out0, 0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_quiet", dequeue, 0);

        run_tri(100, 50, 30, 400, 600, 200);
        chk("post_rst_flip", flipped, 1);
        chk("post_rst_area", $signed(area2), 185500);
        finish_hs;
        chk("post_rst_cull", cull_count, 0);
        chk("all_delivered", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
